// File: rtl/cavlc_bit_packer.sv
// Packs right-aligned CAVLC codewords MSB-first into OUT_W-bit words; flush pads to a word boundary.
// Optional build macro CAVLC_PACK_STOP_BIT_EN appends the rbsp stop bit on flush.
module cavlc_bit_packer #(
    parameter int IN_W  = 128,
    parameter int LEN_W = 7,
    parameter int OUT_W = 32,
    parameter int ACC_W = 192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    input  logic [LEN_W-1:0] in_len,
    output logic             in_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [31:0]      total_bits,
    output logic             overflow_err,
    output logic [1:0]       dbg_state
);
    localparam logic [7:0] OUT_W_F   = 8'(OUT_W);
    localparam logic [7:0] ROOM_F    = 8'(ACC_W - IN_W);
    localparam logic [7:0] IN_W_F    = 8'(IN_W);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_FLUSH = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       fill;

    logic             pop;
    logic             accept;
    logic [7:0]       fill_pop;
    logic [ACC_W-1:0] acc_pop;
    logic [IN_W-1:0]  code_mask;
    logic [ACC_W-1:0] code_al;
    logic [ACC_W-1:0] code_pos;
    logic [7:0]       lsh;
    logic [ACC_W-1:0] acc_acc;
    logic [7:0]       fill_acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [7:0]       fill_nxt;

    // Handshake: a word moves when out_valid && out_ready; a codeword is taken when
    // in_valid && in_ready. Both flags depend only on registered state and fill.
    assign in_ready   = (state == S_RUN) && (fill <= ROOM_F);
    assign out_valid  = (fill >= OUT_W_F) || ((state == S_FLUSH) && (fill != 8'd0));
    assign out_data   = acc[ACC_W-1 -: OUT_W];
    assign out_last   = (state == S_FLUSH) && (fill != 8'd0) && (fill <= OUT_W_F);
    assign flush_done = (state == S_DONE);
    assign dbg_state  = state;

    always_comb begin
        pop      = out_valid && out_ready;
        accept   = in_valid && in_ready;
        fill_pop = fill;
        acc_pop  = acc;
        if (pop) begin
            fill_pop = (fill > OUT_W_F) ? (fill - OUT_W_F) : 8'd0;
            acc_pop  = acc << OUT_W;
        end

        // Mask stray bits above in_len, move the codeword's first bit to the top,
        // then slide it down to sit directly after the post-pop content.
        code_mask = in_code & ((IN_W'(1) << in_len) - IN_W'(1));
        lsh       = IN_W_F - {1'b0, in_len};
        code_al   = {code_mask, {(ACC_W-IN_W){1'b0}}} << lsh;
        code_pos  = code_al >> fill_pop;

        acc_acc  = acc_pop;
        fill_acc = fill_pop;
        if (accept) begin
            acc_acc  = acc_pop | code_pos;
            fill_acc = fill_pop + {1'b0, in_len};
        end

        acc_nxt  = acc_acc;
        fill_nxt = fill_acc;
`ifdef CAVLC_PACK_STOP_BIT_EN
        if ((state == S_RUN) && flush) begin
            acc_nxt  = acc_acc | ({1'b1, {(ACC_W-1){1'b0}}} >> fill_acc);
            fill_nxt = fill_acc + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            acc          <= '0;
            fill         <= 8'd0;
            total_bits   <= 32'd0;
            overflow_err <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
            if (accept)
                total_bits <= total_bits + 32'(in_len);
            if (in_valid && !in_ready)
                overflow_err <= 1'b1;
            case (state)
                S_RUN:   if (flush) state <= S_FLUSH;
                S_FLUSH: if (fill_pop == 8'd0) state <= S_DONE;
                default: state <= S_RUN;
            endcase
        end
    end
endmodule
